// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and constants for the fifo_burst_reader block.
package fifo_burst_reader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int SKID_DEPTH = 2;
   localparam int STAT_WIDTH = 32;
   localparam int CNT_WIDTH  = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/fifo_burst_reader_if.sv
// Bus bundle for fifo_burst_reader: command channel, upstream FWFT read port,
// downstream write port and the word counter.
interface fifo_burst_reader_if #(
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 16
);
   import fifo_burst_reader_pkg::*;

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [LEN_WIDTH-1:0]  cmd_len;
   logic                  done;
   logic                  if_empty_n;
   logic                  if_read_ce;
   logic                  if_read;
   logic [DATA_WIDTH-1:0] if_dout;
   logic                  out_full_n;
   logic                  out_write_ce;
   logic                  out_write;
   logic [DATA_WIDTH-1:0] out_din;
   logic                  out_last;
   logic [STAT_WIDTH-1:0] stat_words;

   modport master (
      input  cmd_valid, cmd_len, if_empty_n, if_dout, out_full_n,
      output cmd_ready, done, if_read_ce, if_read, out_write_ce, out_write,
             out_din, out_last, stat_words
   );

   modport slave (
      output cmd_valid, cmd_len, if_empty_n, if_dout, out_full_n,
      input  cmd_ready, done, if_read_ce, if_read, out_write_ce, out_write,
             out_din, out_last, stat_words
   );
endinterface

// File: rtl/fifo_burst_reader_skid.sv
// Two-entry in-order skid buffer; decouples the upstream pop from the downstream push.
module fifo_burst_reader_skid
   import fifo_burst_reader_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  push_last,
   input  logic                  pop,
   output logic [CNT_WIDTH-1:0]  count,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic                  head_last
);

   logic [DATA_WIDTH-1:0] data_q [SKID_DEPTH];
   logic [SKID_DEPTH-1:0] last_q;
   logic                  rd_ptr;
   logic                  wr_ptr;
   logic [CNT_WIDTH-1:0]  count_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < SKID_DEPTH; i++) data_q[i] <= '0;
         last_q  <= '0;
         rd_ptr  <= 1'b0;
         wr_ptr  <= 1'b0;
         count_q <= '0;
      end else begin
         if (push) begin
            data_q[wr_ptr] <= push_data;
            last_q[wr_ptr] <= push_last;
            wr_ptr         <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         if (push && !pop)      count_q <= count_q + CNT_WIDTH'(1);
         else if (pop && !push) count_q <= count_q - CNT_WIDTH'(1);
      end
   end

   assign count     = count_q;
   assign head_data = data_q[rd_ptr];
   assign head_last = last_q[rd_ptr];

endmodule

// File: rtl/fifo_burst_reader.sv
// Counted-burst mover from an upstream FWFT FIFO to a downstream FIFO.
// Optional word counter is built when FIFO_BURST_READER_STATS_EN is defined.
//
// state | meaning
// IDLE  | ready for a command
// BURST | popping upstream until remaining hits 0
// DRAIN | waiting for the skid to empty, then pulse done
module fifo_burst_reader
   import fifo_burst_reader_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 16
) (
   input logic                 clk,
   input logic                 reset,
   fifo_burst_reader_if.master bus
);

   state_t                state;
   logic [LEN_WIDTH-1:0]  remaining;
   logic                  done_q;
   logic [CNT_WIDTH-1:0]  skid_count;
   logic [DATA_WIDTH-1:0] head_data;
   logic                  head_last;
   logic                  pop_up;
   logic                  push_dn;

   // Both handshakes see only their own FIFO flag plus registered state.
   assign pop_up  = (state == BURST) && (remaining != '0) && bus.if_empty_n &&
                    (skid_count < CNT_WIDTH'(SKID_DEPTH));
   assign push_dn = (skid_count != '0) && bus.out_full_n;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         remaining <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  remaining <= bus.cmd_len;
                  state     <= (bus.cmd_len != '0) ? BURST : DRAIN;
               end
            end
            BURST: begin
               if (pop_up) begin
                  remaining <= remaining - LEN_WIDTH'(1);
                  if (remaining == LEN_WIDTH'(1)) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (skid_count == '0) begin
                  done_q <= 1'b1;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   fifo_burst_reader_skid #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .push      (pop_up),
      .push_data (bus.if_dout),
      .push_last (remaining == LEN_WIDTH'(1)),
      .pop       (push_dn),
      .count     (skid_count),
      .head_data (head_data),
      .head_last (head_last)
   );

   assign bus.cmd_ready    = (state == IDLE);
   assign bus.done         = done_q;
   assign bus.if_read_ce   = 1'b1;
   assign bus.if_read      = pop_up;
   assign bus.out_write_ce = 1'b1;
   assign bus.out_write    = push_dn;
   assign bus.out_din      = head_data;
   assign bus.out_last     = head_last;

`ifdef FIFO_BURST_READER_STATS_EN
   logic [STAT_WIDTH-1:0] stat_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_q <= '0;
      end else if (push_dn && (stat_q != '1)) begin
         stat_q <= stat_q + STAT_WIDTH'(1);
      end
   end

   assign bus.stat_words = stat_q;
`else
   assign bus.stat_words = '0;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader: FIFO models on both sides,
// expected stream derived from the words loaded upstream per burst.
module tb_fifo_burst_reader;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   fifo_burst_reader_if #(.DATA_WIDTH(32), .LEN_WIDTH(16)) bus ();

   fifo_burst_reader #(.DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] up_q[$];
   logic [31:0] exp_d[$];
   logic [31:0] got_d[$];
   bit          got_l[$];

   int cyc = 0;
   int occ, reads, first_rd, first_wr, last_wr, done_cnt, done_cyc;
   int acc_cnt, acc_cyc, gap_reads, gap_cycles, bad_read, bad_full, wr_total;
   int full_mode = 0;
   bit empty_rand = 0;
   int starve_at = -1, starve_len = 0, starve_left = 0;
   bit cmd_v = 0;
   logic [15:0] cmd_len_v = '0;

`ifdef FIFO_BURST_READER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   // One clock cycle: drive at negedge, sample 1ns later, update FIFO models.
   task automatic step();
      bit starve;
      bit emp_ok;
      @(negedge clk);
      if (starve_at >= 0 && reads == starve_at) begin
         starve_left = starve_len;
         starve_at   = -1;
      end
      starve = (starve_left > 0);
      emp_ok = empty_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.cmd_valid  = cmd_v;
      bus.cmd_len    = cmd_len_v;
      bus.if_empty_n = (up_q.size() != 0) && !starve && emp_ok;
      bus.if_dout    = (up_q.size() != 0) ? up_q[0] : 32'h0;
      case (full_mode)
         0:       bus.out_full_n = 1'b1;
         1:       bus.out_full_n = (cyc % 2) == 0;
         2:       bus.out_full_n = ($urandom_range(0, 2) != 0);
         default: bus.out_full_n = 1'b0;
      endcase
      #1;
      if (bus.cmd_valid && bus.cmd_ready) begin
         acc_cnt++;
         acc_cyc = cyc;
      end
      if (bus.if_read && !bus.if_empty_n) bad_read++;
      if (bus.if_read && occ >= 2) bad_full++;
      if (starve) begin
         gap_cycles++;
         if (bus.if_read) gap_reads++;
      end
      if (bus.done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (bus.out_write) begin
         got_d.push_back(bus.out_din);
         got_l.push_back(bus.out_last);
         if (first_wr < 0) first_wr = cyc;
         last_wr = cyc;
         occ--;
         wr_total++;
      end
      if (bus.if_read) begin
         void'(up_q.pop_front());
         if (first_rd < 0) first_rd = cyc;
         reads++;
         occ++;
      end
      if (starve_left > 0) starve_left--;
      cyc++;
   endtask

   task automatic load(input int len, input bit rnd, input logic [31:0] base);
      logic [31:0] d;
      exp_d.delete();
      for (int i = 0; i < len; i++) begin
         d = rnd ? $urandom : base + 32'(i);
         up_q.push_back(d);
         exp_d.push_back(d);
      end
   endtask

   task automatic do_burst(input int len, input bit hold);
      got_d.delete();
      got_l.delete();
      reads = 0; first_rd = -1; first_wr = -1; last_wr = -1;
      done_cnt = 0; done_cyc = -1; acc_cnt = 0; acc_cyc = -1;
      gap_reads = 0; gap_cycles = 0; bad_read = 0; bad_full = 0;
      cmd_len_v = 16'(len);
      cmd_v     = 1'b1;
      for (int i = 0; i < 20 && acc_cnt == 0; i++) step();
      if (hold) begin
         cmd_len_v = 16'd5;
         step();
      end
      cmd_v = 1'b0;
      for (int i = 0; i < 400 && done_cnt == 0; i++) step();
      step();
      step();
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if (bus.cmd_ready !== 1'b1 || bus.done !== 1'b0 || bus.if_read !== 1'b0 ||
          bus.out_write !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_ctrl: got ready=%b done=%b rd=%b wr=%b want 1 0 0 0",
                  bus.cmd_ready, bus.done, bus.if_read, bus.out_write);
      end
      n_checks++;
      if (bus.out_din !== 32'h0 || bus.out_last !== 1'b0 || bus.stat_words !== 32'h0) begin
         n_errors++;
         $display("FAIL reset_data: got din=%h last=%b stat=%0d want 0 0 0",
                  bus.out_din, bus.out_last, bus.stat_words);
      end
      n_checks++;
      if (bus.if_read_ce !== 1'b1 || bus.out_write_ce !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_ce: got %b %b want 1 1", bus.if_read_ce, bus.out_write_ce);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      occ = 0;
      wr_total = 0;
   endtask

   task automatic test_basic();
      full_mode = 0;
      load(4, 1'b0, 32'hA0);
      do_burst(4, 1'b0);
      n_checks++;
      if (got_d.size() != 4) begin
         n_errors++;
         $display("FAIL basic_count: got %0d words want 4", got_d.size());
      end
      for (int i = 0; i < got_d.size() && i < 4; i++) begin
         n_checks++;
         if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 3)) begin
            n_errors++;
            $display("FAIL basic_word[%0d]: got %h/%b want %h/%b",
                     i, got_d[i], got_l[i], exp_d[i], i == 3);
         end
      end
      n_checks++;
      if (first_rd !== acc_cyc + 1 || first_wr !== acc_cyc + 2) begin
         n_errors++;
         $display("FAIL basic_latency: got rd@%0d wr@%0d want rd@%0d wr@%0d",
                  first_rd, first_wr, acc_cyc + 1, acc_cyc + 2);
      end
      n_checks++;
      if (last_wr - first_wr !== 3) begin
         n_errors++;
         $display("FAIL basic_throughput: got span %0d want 3", last_wr - first_wr);
      end
      n_checks++;
      if (done_cnt !== 1 || done_cyc <= last_wr) begin
         n_errors++;
         $display("FAIL basic_done: got %0d pulses at %0d want 1 after %0d",
                  done_cnt, done_cyc, last_wr);
      end
   endtask

   task automatic test_zero_len();
      full_mode = 0;
      load(2, 1'b1, 32'h0);
      do_burst(0, 1'b0);
      n_checks++;
      if (reads !== 0 || got_d.size() != 0) begin
         n_errors++;
         $display("FAIL zero_activity: got %0d reads %0d writes want 0 0", reads, got_d.size());
      end
      n_checks++;
      if (done_cnt !== 1 || done_cyc !== acc_cyc + 2) begin
         n_errors++;
         $display("FAIL zero_done: got %0d pulses at %0d want 1 at %0d",
                  done_cnt, done_cyc, acc_cyc + 2);
      end
      up_q.delete();
   endtask

   task automatic test_backpressure();
      full_mode = 1;
      load(8, 1'b1, 32'h0);
      do_burst(8, 1'b1);
      n_checks++;
      if (got_d.size() != 8 || reads !== 8 || acc_cnt !== 1) begin
         n_errors++;
         $display("FAIL bp_count: got %0d words %0d reads %0d accepts want 8 8 1",
                  got_d.size(), reads, acc_cnt);
      end
      for (int i = 0; i < got_d.size() && i < 8; i++) begin
         n_checks++;
         if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 7)) begin
            n_errors++;
            $display("FAIL bp_word[%0d]: got %h/%b want %h/%b",
                     i, got_d[i], got_l[i], exp_d[i], i == 7);
         end
      end
      n_checks++;
      if (bad_full !== 0 || bad_read !== 0) begin
         n_errors++;
         $display("FAIL bp_read_guard: got %0d full-skid reads %0d empty reads want 0 0",
                  bad_full, bad_read);
      end
      n_checks++;
      if (done_cnt !== 1) begin
         n_errors++;
         $display("FAIL bp_done: got %0d pulses want 1", done_cnt);
      end
      full_mode = 0;
   endtask

   task automatic test_starvation();
      full_mode  = 0;
      starve_at  = 3;
      starve_len = 5;
      load(8, 1'b1, 32'h0);
      do_burst(8, 1'b0);
      n_checks++;
      if (gap_cycles !== 5 || gap_reads !== 0 || bad_read !== 0) begin
         n_errors++;
         $display("FAIL starve_gap: got %0d gap cycles %0d gap reads %0d empty reads want 5 0 0",
                  gap_cycles, gap_reads, bad_read);
      end
      n_checks++;
      if (got_d.size() != 8) begin
         n_errors++;
         $display("FAIL starve_count: got %0d words want 8", got_d.size());
      end
      for (int i = 0; i < got_d.size() && i < 8; i++) begin
         n_checks++;
         if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 7)) begin
            n_errors++;
            $display("FAIL starve_word[%0d]: got %h/%b want %h/%b",
                     i, got_d[i], got_l[i], exp_d[i], i == 7);
         end
      end
      n_checks++;
      if (done_cnt !== 1) begin
         n_errors++;
         $display("FAIL starve_done: got %0d pulses want 1", done_cnt);
      end
   endtask

   task automatic test_random();
      int len;
      int errs;
      full_mode  = 2;
      empty_rand = 1'b1;
      for (int b = 0; b < 6; b++) begin
         len = $urandom_range(1, 24);
         load(len, 1'b1, 32'h0);
         do_burst(len, 1'b0);
         errs = 0;
         for (int i = 0; i < got_d.size() && i < len; i++)
            if (got_d[i] !== exp_d[i] || got_l[i] !== (i == len - 1)) errs++;
         n_checks++;
         if (got_d.size() != len || errs != 0) begin
            n_errors++;
            $display("FAIL rand_stream[%0d]: got %0d words %0d bad want %0d words 0 bad",
                     b, got_d.size(), errs, len);
         end
         n_checks++;
         if (reads !== len || bad_read !== 0 || bad_full !== 0 || done_cnt !== 1) begin
            n_errors++;
            $display("FAIL rand_proto[%0d]: got reads=%0d bad=%0d/%0d done=%0d want %0d 0/0 1",
                     b, reads, bad_read, bad_full, done_cnt, len);
         end
      end
      full_mode  = 0;
      empty_rand = 1'b0;
   endtask

   task automatic test_reset_mid();
      full_mode = 3;
      load(6, 1'b1, 32'h0);
      got_d.delete();
      got_l.delete();
      acc_cnt   = 0;
      cmd_len_v = 16'd6;
      cmd_v     = 1'b1;
      step();
      cmd_v = 1'b0;
      for (int i = 0; i < 20 && occ < 2; i++) step();
      n_checks++;
      if (occ !== 2) begin
         n_errors++;
         $display("FAIL midrst_fill: got skid occupancy %0d want 2", occ);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_checks++;
      if (bus.cmd_ready !== 1'b1 || bus.done !== 1'b0 || bus.if_read !== 1'b0 ||
          bus.out_write !== 1'b0 || bus.out_din !== 32'h0 || bus.out_last !== 1'b0 ||
          bus.stat_words !== 32'h0) begin
         n_errors++;
         $display("FAIL midrst_outputs: got ready=%b done=%b rd=%b wr=%b din=%h last=%b stat=%0d want 1 0 0 0 0 0 0",
                  bus.cmd_ready, bus.done, bus.if_read, bus.out_write, bus.out_din,
                  bus.out_last, bus.stat_words);
      end
      @(negedge clk);
      reset = 1'b1;
      up_q.delete();
      occ = 0;
      wr_total = 0;
      full_mode = 0;
      load(3, 1'b1, 32'h0);
      do_burst(3, 1'b0);
      n_checks++;
      if (got_d.size() != 3) begin
         n_errors++;
         $display("FAIL midrst_count: got %0d words want 3", got_d.size());
      end
      for (int i = 0; i < got_d.size() && i < 3; i++) begin
         n_checks++;
         if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 2)) begin
            n_errors++;
            $display("FAIL midrst_word[%0d]: got %h/%b want %h/%b",
                     i, got_d[i], got_l[i], exp_d[i], i == 2);
         end
      end
      n_checks++;
      if (done_cnt !== 1) begin
         n_errors++;
         $display("FAIL midrst_done: got %0d pulses want 1", done_cnt);
      end
   endtask

   task automatic test_stats();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      occ = 0;
      wr_total = 0;
      full_mode = 2;
      load(4, 1'b1, 32'h0);
      do_burst(4, 1'b0);
      load(8, 1'b1, 32'h0);
      do_burst(8, 1'b0);
      full_mode = 0;
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.stat_words !== (STATS ? 32'd12 : 32'd0)) begin
         n_errors++;
         $display("FAIL stats_words: got %0d want %0d", bus.stat_words, STATS ? 12 : 0);
      end
      n_checks++;
      if (wr_total !== 12) begin
         n_errors++;
         $display("FAIL stats_traffic: got %0d pushes want 12", wr_total);
      end
   endtask

   initial begin
      bus.cmd_valid  = 1'b0;
      bus.cmd_len    = '0;
      bus.if_empty_n = 1'b0;
      bus.if_dout    = '0;
      bus.out_full_n = 1'b1;
      test_reset();
      test_basic();
      test_zero_len();
      test_backpressure();
      test_starvation();
      test_random();
      test_reset_mid();
      test_stats();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
